// File: rtl/titan_spi_pkg.sv
// Shared types and constants for the titan SPI register bank: FSM states,
// command byte layout and SPI mode decoding.
package titan_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_W = 7;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

  // Modes 0 and 3 sample on the rising SPI edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return mode[1] == mode[0];
  endfunction

endpackage

// File: rtl/titan_spi_sync.sv
// Two-flop synchroniser with edge detection for one asynchronous SPI input.
module titan_spi_sync (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchroniser stages plus one history flop for edge detection
  always_ff @(posedge clk) begin
    meta_p0 <= d;
    sync_p1 <= meta_p0;
    prev_p2 <= sync_p1;
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/titan_spi_regbank.sv
// SPI target exposing a bank of NUM_REGS registers of DATA_W bits.
// Define TITAN_SPI_AUTOINC_EN to let a frame continue over consecutive addresses.
module titan_spi_regbank
  import titan_spi_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SPI_MODE = 0
) (
  input  logic                          sys_clock_i,
  input  logic                          sys_reset_ni,
  input  logic                          spi_clock_i,
  input  logic                          spi_cs_i,
  input  logic                          spi_pico_i,
  output logic                          spi_poci_o,
  output logic                          spi_poci_oeb_o,
  output logic [NUM_REGS*DATA_W-1:0]    regs_o,
  output logic                          wr_valid_o,
  output logic [$clog2(NUM_REGS)-1:0]   wr_addr_o,
  output logic                          busy_o
);

  localparam int         ADDR_W      = $clog2(NUM_REGS);
  localparam logic       CPHA        = mode_cpha(2'(SPI_MODE));
  localparam logic       SAMPLE_RISE = sample_on_rise(2'(SPI_MODE));
  localparam logic [5:0] CMD_LAST    = 6'(CMD_W - 1);
  localparam logic [5:0] WORD_LAST   = 6'(DATA_W - 1);
`ifdef TITAN_SPI_AUTOINC_EN
  localparam logic       AUTOINC     = 1'b1;
`else
  localparam logic       AUTOINC     = 1'b0;
`endif

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic pico_q, pico_rise, pico_fall;

  titan_spi_sync u_sync_sck  (.clk(sys_clock_i), .d(spi_clock_i), .q(sck_q),  .rise(sck_rise),  .fall(sck_fall));
  titan_spi_sync u_sync_cs   (.clk(sys_clock_i), .d(spi_cs_i),    .q(cs_q),   .rise(cs_rise),   .fall(cs_fall));
  titan_spi_sync u_sync_pico (.clk(sys_clock_i), .d(spi_pico_i),  .q(pico_q), .rise(pico_rise), .fall(pico_fall));

  logic unused_sync;
  assign unused_sync = ^{sck_q, cs_rise, pico_rise, pico_fall};

  spi_state_e                state, state_nxt;
  logic [5:0]                cnt;
  logic [DATA_W-1:0]         rx;
  logic [DATA_W:0]           tx;
  logic                      cmd_wr;
  logic [CMD_ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]         regs [NUM_REGS];

  // Edges seen together with a CS rise are dropped so an aborted word never completes
  logic smp, shf;
  assign smp = ~cs_q & (SAMPLE_RISE ? sck_rise : sck_fall);
  assign shf = ~cs_q & (SAMPLE_RISE ? sck_fall : sck_rise);

  logic [CMD_W-1:0]      cmd_word;
  logic [DATA_W-1:0]     data_word;
  logic [CMD_ADDR_W-1:0] cmd_addr, addr_inc;
  logic                  cmd_done, word_done;
  assign cmd_word  = {rx[CMD_W-2:0], pico_q};
  assign data_word = {rx[DATA_W-2:0], pico_q};
  assign cmd_addr  = cmd_word[CMD_ADDR_W-1:0];
  assign addr_inc  = (32'(addr) == NUM_REGS - 1) ? '0 : addr + 1'b1;
  assign cmd_done  = (state == ST_CMD)  && smp && (cnt == CMD_LAST);
  assign word_done = (state == ST_DATA) && smp && (cnt == WORD_LAST);

  function automatic logic in_range(input logic [CMD_ADDR_W-1:0] a);
    return (32'(a) >> ADDR_W) == 0;
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [CMD_ADDR_W-1:0] a);
    return in_range(a) ? regs[a[ADDR_W-1:0]] : '0;
  endfunction

  // CPHA=0 presents the MSB immediately; CPHA=1 holds it back until the first shift edge
  function automatic logic [DATA_W:0] tx_load(input logic [DATA_W-1:0] v);
    return CPHA ? {1'b0, v} : {v, 1'b0};
  endfunction

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_ni) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_q) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = cs_fall ? ST_CMD : ST_IGNORE;
        ST_CMD:  if (cmd_done)  state_nxt = ST_DATA;
        ST_DATA: if (word_done) state_nxt = AUTOINC ? ST_DATA : ST_IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy_o         = (state != ST_IDLE);
    spi_poci_oeb_o = !((state == ST_DATA) && !cmd_wr);
    spi_poci_o     = !spi_poci_oeb_o && tx[DATA_W];
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_ni) begin
      cnt        <= '0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid_o <= 1'b0;
      if (state == ST_CMD || state == ST_DATA) begin
        if (cmd_done || word_done) cnt <= '0;
        else if (smp)              cnt <= cnt + 6'd1;
      end else begin
        cnt <= '0;
      end
      if (word_done && cmd_wr && in_range(addr)) begin
        regs[addr[ADDR_W-1:0]] <= data_word;
        wr_valid_o             <= 1'b1;
        wr_addr_o              <= addr[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge sys_clock_i) begin
    if ((state == ST_CMD || state == ST_DATA) && smp) rx <= data_word;
    if (cmd_done) begin
      cmd_wr <= cmd_word[CMD_WR_BIT];
      addr   <= cmd_addr;
      tx     <= tx_load(read_reg(cmd_addr));
    end else if (word_done && AUTOINC) begin
      addr <= addr_inc;
      tx   <= tx_load(read_reg(addr_inc));
    end else if (state == ST_DATA && shf && (CPHA || cnt != '0)) begin
      tx <= {tx[DATA_W-1:0], 1'b0};
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_titan_spi_regbank.sv
// Directed bench for titan_spi_regbank: one instance in SPI mode 0, one in mode 3.
`timescale 1ns/1ps
module tb_titan_spi_regbank;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int HALF     = 60;

  logic sys_clock = 1'b0;
  logic sys_reset_n = 1'b0;
  logic sclk0 = 1'b0, cs0 = 1'b1;
  logic sclk3 = 1'b1, cs3 = 1'b1;
  logic pico = 1'b0;
  logic poci0, oeb0, wrv0, busy0;
  logic poci3, oeb3, wrv3, busy3;
  logic [NUM_REGS*DATA_W-1:0] regs0, regs3;
  logic [2:0] wra0, wra3;

  always #5 sys_clock = ~sys_clock;

  titan_spi_regbank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SPI_MODE(0)) dut0 (
    .sys_clock_i(sys_clock), .sys_reset_ni(sys_reset_n), .spi_clock_i(sclk0),
    .spi_cs_i(cs0), .spi_pico_i(pico), .spi_poci_o(poci0), .spi_poci_oeb_o(oeb0),
    .regs_o(regs0), .wr_valid_o(wrv0), .wr_addr_o(wra0), .busy_o(busy0));

  titan_spi_regbank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SPI_MODE(3)) dut3 (
    .sys_clock_i(sys_clock), .sys_reset_ni(sys_reset_n), .spi_clock_i(sclk3),
    .spi_cs_i(cs3), .spi_pico_i(pico), .spi_poci_o(poci3), .spi_poci_oeb_o(oeb3),
    .regs_o(regs3), .wr_valid_o(wrv3), .wr_addr_o(wra3), .busy_o(busy3));

  int n_chk = 0;
  int n_fail = 0;
  int pulses0 = 0, pulses3 = 0;
  logic [2:0] last_wa0 = '0, last_wa3 = '0;
  int mode = 0;

  always @(negedge sys_clock) begin
    if (wrv0) begin pulses0++; last_wa0 = wra0; end
    if (wrv3) begin pulses3++; last_wa3 = wra3; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reg0(input int n);
    return regs0[n*DATA_W +: DATA_W];
  endfunction

  function automatic logic [15:0] reg3(input int n);
    return regs3[n*DATA_W +: DATA_W];
  endfunction

  task automatic set_clk(input logic v);
    if (mode == 3) sclk3 = v; else sclk0 = v;
  endtask

  task automatic set_cs(input logic v);
    if (mode == 3) cs3 = v; else cs0 = v;
  endtask

  function automatic logic cur_poci();
    return (mode == 3) ? poci3 : poci0;
  endfunction

  function automatic logic cur_oeb();
    return (mode == 3) ? oeb3 : oeb0;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  // Shift n bits MSB first; capture POCI and its enable just before each sample edge
  task automatic xfer(input int n, input logic [31:0] d, output logic [31:0] rx, output int oeb_lo);
    rx = '0;
    oeb_lo = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (mode == 3) set_clk(1'b0);
      pico = d[i];
      #HALF;
      rx = {rx[30:0], cur_poci()};
      if (!cur_oeb()) oeb_lo++;
      set_clk(1'b1);
      #HALF;
      if (mode == 0) set_clk(1'b0);
    end
  endtask

  task automatic cs_begin();
    set_cs(1'b0);
    #HALF;
  endtask

  task automatic cs_end();
    #HALF;
    set_cs(1'b1);
    cycles(8);
  endtask

  task automatic frame(input logic [7:0] cmd, input int nbits, input logic [31:0] data,
                       output logic [31:0] cmd_rx, output int cmd_oeb_lo,
                       output logic [31:0] rdata, output int data_oeb_lo);
    cs_begin();
    xfer(8, {24'h0, cmd}, cmd_rx, cmd_oeb_lo);
    xfer(nbits, data, rdata, data_oeb_lo);
    cs_end();
  endtask

  logic [31:0] crx, rd, dummy;
  int coe, doe, tmp_oe;
  logic [NUM_REGS*DATA_W-1:0] snap;

  initial begin
    cycles(6);
    chk("rst_regs0_zero", {31'h0, regs0 == '0}, 32'h1);
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_wrv0", {31'h0, wrv0}, 32'h0);
    chk("rst_oeb0", {31'h0, oeb0}, 32'h1);
    chk("rst_poci0", {31'h0, poci0}, 32'h0);
    chk("rst_oeb3", {31'h0, oeb3}, 32'h1);
    sys_reset_n = 1'b1;
    cycles(4);

    // mode 0 write then read
    mode = 0;
    frame(8'h83, 16, 32'h0000BEEF, crx, coe, rd, doe);
    chk("wr_reg3", {16'h0, reg0(3)}, 32'h0000BEEF);
    chk("wr_pulses", pulses0, 1);
    chk("wr_addr", {29'h0, last_wa0}, 32'h3);
    chk("wr_cmd_oeb_lo", coe, 0);
    chk("wr_data_oeb_lo", doe, 0);

    frame(8'h03, 16, 32'h0, crx, coe, rd, doe);
    chk("rd_data", rd, 32'h0000BEEF);
    chk("rd_cmd_oeb_lo", coe, 0);
    chk("rd_cmd_poci", crx, 32'h0);
    chk("rd_data_oeb_lo", doe, 16);
    chk("rd_oeb_after", {31'h0, oeb0}, 32'h1);
    chk("rd_no_pulse", pulses0, 1);

    // mode 3 write then read
    mode = 3;
    frame(8'h83, 16, 32'h0000BEEF, crx, coe, rd, doe);
    chk("m3_wr_reg3", {16'h0, reg3(3)}, 32'h0000BEEF);
    chk("m3_wr_pulses", pulses3, 1);
    chk("m3_wr_addr", {29'h0, last_wa3}, 32'h3);
    frame(8'h03, 16, 32'h0, crx, coe, rd, doe);
    chk("m3_rd_data", rd, 32'h0000BEEF);
    chk("m3_rd_cmd_oeb_lo", coe, 0);
    chk("m3_rd_data_oeb_lo", doe, 16);
    chk("m3_rd_oeb_after", {31'h0, oeb3}, 32'h1);
    mode = 0;

    // abort after 10 data bits
    frame(8'h82, 10, 32'h000002AB, crx, coe, rd, doe);
    chk("abort_pulses", pulses0, 1);
    chk("abort_reg2", {16'h0, reg0(2)}, 32'h0);
    chk("abort_busy_after", {31'h0, busy0}, 32'h0);

    // two words starting at the last address
    frame(8'h87, 32, 32'h11112222, crx, coe, rd, doe);
    chk("ai_reg7", {16'h0, reg0(7)}, 32'h00001111);
`ifdef TITAN_SPI_AUTOINC_EN
    chk("ai_reg0", {16'h0, reg0(0)}, 32'h00002222);
    chk("ai_pulses", pulses0, 3);
    chk("ai_last_addr", {29'h0, last_wa0}, 32'h0);
`else
    chk("ai_reg0", {16'h0, reg0(0)}, 32'h0);
    chk("ai_pulses", pulses0, 2);
    chk("ai_last_addr", {29'h0, last_wa0}, 32'h7);
`endif

    // out-of-range write and read
    snap = regs0;
    frame(8'h90, 16, 32'h0000AAAA, crx, coe, rd, doe);
    chk("oor_wr_pulses", pulses0, 3 - (`ifdef TITAN_SPI_AUTOINC_EN 0 `else 1 `endif));
    chk("oor_wr_regs", {31'h0, regs0 == snap}, 32'h1);
    frame(8'h10, 16, 32'h0, crx, coe, rd, doe);
    chk("oor_rd_data", rd, 32'h0);
    chk("oor_rd_oeb_lo", doe, 16);

    // reset during the data phase with CS held low
    frame(8'h81, 16, 32'h00001234, crx, coe, rd, doe);
    chk("pre_rst_reg1", {16'h0, reg0(1)}, 32'h00001234);
    snap = regs0;
    cs_begin();
    xfer(8, 32'h00000085, crx, coe);
    xfer(6, 32'h0000003F, dummy, tmp_oe);
    sys_reset_n = 1'b0;
    cycles(3);
    chk("mid_rst_regs_zero", {31'h0, regs0 == '0}, 32'h1);
    chk("mid_rst_busy", {31'h0, busy0}, 32'h0);
    sys_reset_n = 1'b1;
    cycles(2);
    tmp_oe = pulses0;
    xfer(10, 32'h000003FF, dummy, coe);
    xfer(8, 32'h00000081, dummy, coe);
    xfer(16, 32'h0000FFFF, dummy, coe);
    chk("post_rst_ignore_busy", {31'h0, busy0}, 32'h1);
    chk("post_rst_no_pulse", pulses0, tmp_oe);
    chk("post_rst_regs_zero", {31'h0, regs0 == '0}, 32'h1);
    cs_end();
    chk("post_rst_idle", {31'h0, busy0}, 32'h0);
    frame(8'h85, 16, 32'h00005A5A, crx, coe, rd, doe);
    chk("post_rst_reg5", {16'h0, reg0(5)}, 32'h00005A5A);
    chk("post_rst_pulse", pulses0, tmp_oe + 1);
    chk("post_rst_addr", {29'h0, last_wa0}, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/titan_spi_regbank.md
TITAN_SPI_REGBANK -- requirements
Module: titan_spi_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and SPI data word width, legal 8..32.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count, power of two, legal 2..128.
REQ-003 SHALL have parameter SPI_MODE, default 0, SPI mode 0..3 (bit1 = CPOL, bit0 = CPHA).
REQ-004 SHALL have one clock and synchronous active-low reset: sys_clock_i in 1, system clock; sys_reset_ni in 1, reset active low, sampled on rising sys_clock_i.
REQ-005 SHALL have spi_clock_i in 1, SPI clock, asynchronous to sys_clock_i.
REQ-006 SHALL have spi_cs_i in 1, chip select, active low.
REQ-007 SHALL have spi_pico_i in 1, controller-to-target data.
REQ-008 SHALL have spi_poci_o out 1, target-to-controller data, MSB first.
REQ-009 SHALL have spi_poci_oeb_o out 1, POCI pad output-enable, active low.
REQ-010 SHALL have regs_o out NUM_REGS*DATA_W, flattened register file; reg n at bits [n*DATA_W +: DATA_W].
REQ-011 SHALL have wr_valid_o out 1, one-cycle write pulse, and wr_addr_o out $clog2(NUM_REGS), address of that write.
REQ-012 SHALL have busy_o out 1, high while a frame is in progress.

Function
REQ-013 SHALL pass spi_clock_i, spi_cs_i and spi_pico_i through a 2-flop synchroniser before use; SPI half-period SHALL be at least 4 sys_clock_i cycles.
REQ-014 SHALL use the rising SPI edge as the sample edge when CPOL equals CPHA, otherwise the falling edge; the opposite edge is the shift edge.
REQ-015 SHALL receive each frame as an 8-bit command (bit7 = 1 for write, bits6:0 = address), then DATA_W-bit data words, all MSB first.
REQ-016 SHALL run a state machine with states IDLE, CMD, DATA and IGNORE.
REQ-017 SHALL go IDLE->CMD on the synchronised CS falling edge, CMD->DATA after the 8th command bit is sampled, and any state->IDLE when CS is high.
REQ-018 SHALL, on a write, update the addressed register and pulse wr_valid_o with wr_addr_o in the sys cycle after the last data bit's sample edge is detected.
REQ-019 SHALL, on a read, load the addressed register into the transmit shifter when the command completes; with CPHA=0 the MSB appears on spi_poci_o before the first data sample edge, with CPHA=1 it appears on the first data shift edge.
REQ-020 SHALL drive spi_poci_oeb_o low only in the DATA state of a read, otherwise high, and SHALL hold spi_poci_o at 0 when not driving.
REQ-021 SHALL ignore writes to addresses >= NUM_REGS (no wr_valid_o pulse) and return all zeros on reads from them.
REQ-022 SHALL abort the frame with no write when CS rises mid-word; a sample edge detected in the same sys cycle as the CS rise SHALL be discarded.
REQ-023 SHALL enter IGNORE after the final word of a frame and stay there, with no further writes, until CS is high.

Reset
REQ-024 SHALL, while sys_reset_ni is low, clear all registers, set wr_valid_o, wr_addr_o and busy_o to 0, set spi_poci_o to 0 and spi_poci_oeb_o to 1, and enter IDLE.
REQ-025 SHALL, when reset is released with CS synchronised low, enter IGNORE until CS is high.

Configuration
REQ-026 SHALL, with macro TITAN_SPI_AUTOINC_EN defined, continue a frame past its first data word: each further word uses address+1, wrapping from NUM_REGS-1 to 0.
REQ-027 SHALL, without TITAN_SPI_AUTOINC_EN, treat every frame as a single data word and then apply REQ-023.

Structure
REQ-028 SHALL place the state enum, the command field constants (write-bit index, address field width) and the SPI_MODE decode helpers in package titan_spi_pkg.
REQ-029 SHALL implement synchronisation and edge detection in sub-module titan_spi_sync, instantiated once per SPI input.

Verification (DATA_W=16, NUM_REGS=8, SPI_MODE=0 unless stated)
REQ-030 SHALL test a write: cmd 0x83 with data 0xBEEF -> regs[3]=0xBEEF, and exactly one wr_valid_o pulse with wr_addr_o=3.
REQ-031 SHALL test a read: cmd 0x03 after REQ-030 -> spi_poci_o shifts out 0xBEEF MSB first, and spi_poci_oeb_o is low only during the data phase; repeat for SPI_MODE=3.
REQ-032 SHALL test an abort: write cmd 0x82, raise CS after 10 data bits -> no wr_valid_o pulse and regs[2] unchanged.
REQ-033 SHALL test auto-increment: cmd 0x87 with data 0x1111 then 0x2222 -> with the macro, regs[7]=0x1111 and regs[0]=0x2222; without it, regs[0] is unchanged.
REQ-034 SHALL test out-of-range addresses: write 0x90 with 0xAAAA -> no write pulse; read 0x10 -> 0x0000.
REQ-035 SHALL test reset mid-frame: assert sys_reset_ni low during the data phase with CS low -> all regs 0, and later bits are ignored until CS goes high.
